// File: rtl/pm_pkg.sv
// Shared definitions for the PM sensor receive path: receiver states, link
// defaults, and the frame constants that the UART and the frame parser both use.
package pm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int PM_CLK_FREQ = 50_000_000;
  localparam int PM_BAUD     = 9600;

  localparam logic [7:0] PM_HDR0      = 8'h42;
  localparam logic [7:0] PM_HDR1      = 8'h4D;
  localparam int         PM_FRAME_LEN = 32;

endpackage : pm_pkg

// File: rtl/pm_rx_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high.
// It resets to 1 so that leaving reset never looks like a falling edge.
module pm_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : pm_rx_sync

// File: rtl/pm_uart_rx.sv
// 8N1 UART receiver for the PM sensor link. Each bit is sampled at its centre, LSB first.
// A good byte produces a one-cycle 'over' strobe. A low stop bit produces a one-cycle 'frame_err'.
module pm_uart_rx
  import pm_pkg::*;
#(
  parameter int CLK_FREQ = PM_CLK_FREQ,
  parameter int BAUD     = PM_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] message_mid,
  output logic       over,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

  logic rx_s;

  pm_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       msg_q, msg_d;
  logic             over_q, over_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      msg_q     <= '0;
      over_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      msg_q     <= msg_d;
      over_q    <= over_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    msg_d     = msg_q;
    over_d    = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // Re-check the start bit at its centre; a high level here was a glitch.
      ST_START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Leaving at mid-stop leaves half a bit to catch a back-to-back start bit.
      ST_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            msg_d   = shreg_q;
            over_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign message_mid = msg_q;
  assign over        = over_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule : pm_uart_rx
